// File: rtl/lsu_control.sv
// Memory-access stage between execute and write-back: issues single-beat
// data-bus requests, builds store byte lanes and sign/zero-extends load data.
module lsu_control #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mem_ren,
  input  logic            i_mem_wen,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_reg_wena,
  output logic            o_req,
  output logic            o_we,
  output logic [XLEN-1:0] o_addr,
  output logic [XLEN-1:0] o_wdata,
  output logic [3:0]      o_wstrb,
  input  logic            i_gnt,
  input  logic            i_rsp_valid,
  input  logic [XLEN-1:0] i_rsp_data,
  input  logic            i_rsp_err,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_reg_wena,
  output logic            o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_r;
  logic [1:0]      size_r;
  logic            zext_r;
  logic [1:0]      offset_r;
  logic            is_store_r;
  logic            reg_wena_r;

  logic            is_mem_s;
  logic            misaligned_s;
  logic [3:0]      wstrb_s;
  logic [XLEN-1:0] wdata_s;
  logic            rsp_take_s;
  logic [XLEN-1:0] rsp_result_s;
  logic            rsp_err_s;
  logic            rsp_wena_s;

  // Picks the addressed byte/halfword out of a full read word and extends it.
  function automatic logic [XLEN-1:0] format_load(
    input logic [XLEN-1:0] data,
    input logic [1:0]      size,
    input logic            zext,
    input logic [1:0]      offset
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = data[{offset, 3'b000} +: 8];
    half_v = data[{offset[1], 4'b0000} +: 16];
    case (size)
      2'b00:   format_load = {{(XLEN-8){~zext & byte_v[7]}}, byte_v};
      2'b01:   format_load = {{(XLEN-16){~zext & half_v[15]}}, half_v};
      default: format_load = data;
    endcase
  endfunction

  assign o_ready = (state_r == ST_IDLE);

  // Decode access size, alignment and store byte lanes of the offered instruction.
  always_comb begin
    is_mem_s     = i_mem_ren | i_mem_wen;
    misaligned_s = 1'b0;
    wstrb_s      = 4'b0000;
    wdata_s      = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        misaligned_s = 1'b0;
        wstrb_s      = 4'b0001 << i_addr[1:0];
        wdata_s      = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        misaligned_s = i_addr[0];
        wstrb_s      = 4'b0011 << i_addr[1:0];
        wdata_s      = {2{i_wdata[15:0]}};
      end
      default: begin
        misaligned_s = |i_addr[1:0];
        wstrb_s      = 4'b1111;
        wdata_s      = i_wdata;
      end
    endcase
  end

  // A response is consumed in WAIT, or in REQ when it coincides with the grant.
  always_comb begin
    rsp_take_s   = 1'b0;
    rsp_result_s = {XLEN{1'b0}};
    rsp_err_s    = 1'b0;
    rsp_wena_s   = 1'b0;
    if (state_r == ST_REQ) begin
      rsp_take_s = i_gnt & i_rsp_valid;
    end else if (state_r == ST_WAIT) begin
      rsp_take_s = i_rsp_valid;
    end else begin
      rsp_take_s = 1'b0;
    end
    if (i_rsp_err) begin
      rsp_result_s = {XLEN{1'b0}};
      rsp_err_s    = 1'b1;
      rsp_wena_s   = 1'b0;
    end else if (is_store_r) begin
      rsp_result_s = {XLEN{1'b0}};
      rsp_err_s    = 1'b0;
      rsp_wena_s   = 1'b0;
    end else begin
      rsp_result_s = format_load(i_rsp_data, size_r, zext_r, offset_r);
      rsp_err_s    = 1'b0;
      rsp_wena_s   = reg_wena_r;
    end
  end

  // Stage FSM with registered bus-request and write-back outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      size_r     <= 2'b00;
      zext_r     <= 1'b0;
      offset_r   <= 2'b00;
      is_store_r <= 1'b0;
      reg_wena_r <= 1'b0;
      o_req      <= 1'b0;
      o_we       <= 1'b0;
      o_addr     <= {XLEN{1'b0}};
      o_wdata    <= {XLEN{1'b0}};
      o_wstrb    <= 4'b0000;
      o_valid    <= 1'b0;
      o_result   <= {XLEN{1'b0}};
      o_reg_wena <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            size_r     <= i_funct3[1:0];
            zext_r     <= i_funct3[2];
            offset_r   <= i_addr[1:0];
            is_store_r <= i_mem_wen;
            reg_wena_r <= i_reg_wena;
            if (!is_mem_s) begin
              state_r    <= ST_DONE;
              o_valid    <= 1'b1;
              o_result   <= i_addr;
              o_reg_wena <= i_reg_wena;
              o_err      <= 1'b0;
            end else if (misaligned_s) begin
              state_r    <= ST_DONE;
              o_valid    <= 1'b1;
              o_result   <= {XLEN{1'b0}};
              o_reg_wena <= 1'b0;
              o_err      <= 1'b1;
            end else begin
              // Both enables set is an illegal encoding and behaves as a store.
              state_r <= ST_REQ;
              o_req   <= 1'b1;
              o_we    <= i_mem_wen;
              o_addr  <= {i_addr[XLEN-1:2], 2'b00};
              o_wdata <= i_mem_wen ? wdata_s : {XLEN{1'b0}};
              o_wstrb <= i_mem_wen ? wstrb_s : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          if (i_gnt) begin
            o_req   <= 1'b0;
            state_r <= i_rsp_valid ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_rsp_valid) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_r <= ST_IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_req   <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
      if (rsp_take_s) begin
        o_valid    <= 1'b1;
        o_result   <= rsp_result_s;
        o_err      <= rsp_err_s;
        o_reg_wena <= rsp_wena_s;
      end
    end
  end

endmodule

// File: tb/tb_lsu_control.sv
// Self-checking bench for lsu_control: transaction-level reference model plus
// a per-cycle compare process driven by the bench's own transaction timeline.
module tb_lsu_control;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_reg_wena;
  logic        o_req;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_gnt;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_reg_wena;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  lsu_control #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_reg_wena(i_reg_wena),
    .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .i_gnt(i_gnt), .i_rsp_valid(i_rsp_valid),
    .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result), .o_reg_wena(o_reg_wena),
    .o_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  // Transaction timeline owned by the driver, read by the compare process.
  logic chk_en = 1'b0, busy = 1'b0, req_allowed = 1'b0, valid_allowed = 1'b0;
  logic        chk_result = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_result = 32'h0;
  logic [3:0]  e_wstrb = 4'h0;
  logic        e_we = 1'b0, e_err = 1'b0, e_wena = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one instruction, straight from the access rules.
  task automatic model(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic wena,
                       input logic [31:0] rd, input logic rerr,
                       output logic mem, output logic mis);
    logic [31:0] lane;
    int sh;
    mem = ren | wen;
    mis = mem && ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0));
    e_addr = {a[31:2], 2'b00};
    e_we   = wen;
    sh     = 8 * a[1:0];
    e_wstrb = 4'b0000;
    e_wdata = 32'h0;
    if (wen) begin
      if (f3[1:0] == 2'd0) begin
        e_wstrb = 4'b0001 << a[1:0];
        e_wdata = {4{wd[7:0]}};
      end else if (f3[1:0] == 2'd1) begin
        e_wstrb = 4'b0011 << a[1:0];
        e_wdata = {2{wd[15:0]}};
      end else begin
        e_wstrb = 4'b1111;
        e_wdata = wd;
      end
    end
    e_err = 1'b0; e_wena = 1'b0; e_result = 32'h0; chk_result = 1'b1;
    lane = rd >> sh;
    if (!mem) begin
      e_result = a;
      e_wena   = wena;
    end else if (mis) begin
      e_err = 1'b1;
      chk_result = 1'b0;
    end else if (rerr) begin
      e_err = 1'b1;
    end else if (wen) begin
      chk_result = 1'b0;
    end else begin
      e_wena = wena;
      case (f3)
        3'b000:  e_result = 32'($signed(lane[7:0]));
        3'b001:  e_result = 32'($signed(lane[15:0]));
        3'b100:  e_result = {24'h0, lane[7:0]};
        3'b101:  e_result = {16'h0, lane[15:0]};
        default: e_result = rd;
      endcase
    end
  endtask

  // Every cycle: handshake timing and, when meaningful, the output payloads.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("o_ready", {31'h0, o_ready}, {31'h0, ~busy});
      check("o_req", {31'h0, o_req}, {31'h0, req_allowed});
      check("o_valid", {31'h0, o_valid}, {31'h0, valid_allowed});
      if (req_allowed) begin
        check("o_addr", o_addr, e_addr);
        check("o_we", {31'h0, o_we}, {31'h0, e_we});
        check("o_wstrb", {28'h0, o_wstrb}, {28'h0, e_wstrb});
        if (e_we) check("o_wdata", o_wdata, e_wdata);
      end
      if (valid_allowed) begin
        check("o_err", {31'h0, o_err}, {31'h0, e_err});
        check("o_reg_wena", {31'h0, o_reg_wena}, {31'h0, e_wena});
        if (chk_result) check("o_result", o_result, e_result);
      end
    end
  end

  task automatic run_txn(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic wena,
                         input int gd, input int rdl, input int rdy,
                         input logic [31:0] rdata, input logic rerr, input logic together);
    logic mem, mis;
    model(ren, wen, f3, a, wd, wena, rdata, rerr, mem, mis);
    i_valid = 1'b1; i_mem_ren = ren; i_mem_wen = wen; i_funct3 = f3;
    i_addr = a; i_wdata = wd; i_reg_wena = wena;
    check("accept_ready", {31'h0, o_ready}, 32'h1);
    @(posedge i_clk); #1;
    busy = 1'b1;
    i_valid = 1'b0;
    i_mem_ren = 1'($urandom_range(0, 1)); i_mem_wen = 1'($urandom_range(0, 1));
    i_funct3 = 3'($urandom_range(0, 7)); i_addr = $urandom; i_wdata = $urandom;
    i_reg_wena = 1'($urandom_range(0, 1));
    if (mem && !mis) begin
      req_allowed = 1'b1;
      repeat (gd) begin @(posedge i_clk); #1; end
      i_gnt = 1'b1;
      if (together) begin
        i_rsp_valid = 1'b1; i_rsp_data = rdata; i_rsp_err = rerr;
      end
      @(posedge i_clk); #1;
      i_gnt = 1'b0;
      req_allowed = 1'b0;
      if (!together) begin
        repeat (rdl) begin @(posedge i_clk); #1; end
        i_rsp_valid = 1'b1; i_rsp_data = rdata; i_rsp_err = rerr;
        @(posedge i_clk); #1;
      end
      i_rsp_valid = 1'b0; i_rsp_data = $urandom; i_rsp_err = 1'b0;
    end
    valid_allowed = 1'b1;
    repeat (rdy) begin @(posedge i_clk); #1; end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    valid_allowed = 1'b0;
    busy = 1'b0;
  endtask

  initial begin
    logic m_t, x_t;
    logic [2:0] f3;
    logic [31:0] a;
    logic ren, wen;
    int kind;
    i_rst = 1'b1; i_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_funct3 = 3'd0;
    i_addr = 32'h0; i_wdata = 32'h0; i_reg_wena = 1'b0; i_gnt = 1'b0;
    i_rsp_valid = 1'b0; i_rsp_data = 32'h0; i_rsp_err = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("rst_ready", {31'h0, o_ready}, 32'h1);
    check("rst_req", {31'h0, o_req}, 32'h0);
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_result", o_result, 32'h0);
    check("rst_wstrb", {28'h0, o_wstrb}, 32'h0);
    chk_en = 1'b1;

    // Hand-computed pins of the model, each followed by the matching transaction.
    model(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 32'h0, 1'b0, m_t, x_t);
    check("pin_pass", e_result, 32'h0000_1234);
    run_txn(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 0, 0, 0, 32'h0, 1'b0, 1'b0);
    model(1'b1, 1'b0, 3'b000, 32'h8003, 32'h0, 1'b1, 32'h80FF_0102, 1'b0, m_t, x_t);
    check("pin_lb", e_result, 32'hFFFF_FF80);
    check("pin_lb_addr", e_addr, 32'h0000_8000);
    run_txn(1'b1, 1'b0, 3'b000, 32'h8003, 32'h0, 1'b1, 2, 3, 0, 32'h80FF_0102, 1'b0, 1'b0);
    model(1'b1, 1'b0, 3'b101, 32'h8002, 32'h0, 1'b1, 32'hBEEF_0000, 1'b0, m_t, x_t);
    check("pin_lhu", e_result, 32'h0000_BEEF);
    run_txn(1'b1, 1'b0, 3'b101, 32'h8002, 32'h0, 1'b1, 0, 1, 1, 32'hBEEF_0000, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 1'b1, 1, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0);
    model(1'b0, 1'b1, 3'b000, 32'h101, 32'hAA, 1'b1, 32'h0, 1'b0, m_t, x_t);
    check("pin_sb_strb", {28'h0, e_wstrb}, 32'h2);
    check("pin_sb_data", e_wdata, 32'hAAAA_AAAA);
    run_txn(1'b0, 1'b1, 3'b000, 32'h101, 32'hAA, 1'b1, 1, 1, 0, 32'h0, 1'b0, 1'b0);
    model(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234, 1'b1, 32'h0, 1'b0, m_t, x_t);
    check("pin_sh_strb", {28'h0, e_wstrb}, 32'hC);
    check("pin_sh_data", e_wdata, 32'h1234_1234);
    run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234, 1'b1, 0, 0, 0, 32'h0, 1'b0, 1'b1);
    model(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 32'h0, 1'b0, m_t, x_t);
    check("pin_mis", {30'h0, x_t, e_err}, 32'h3);
    run_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, 0, 0, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 0, 2, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_txn(1'b1, 1'b0, 3'b000, 32'h8003, 32'h0, 1'b1, 0, 0, 5, 32'h80FF_0102, 1'b0, 1'b1);
    run_txn(1'b1, 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 1'b1, 1, 0, 2, 32'h0, 1'b0, 1'b0);

    // Reset while waiting for the response, then a late response in IDLE.
    model(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0, 1'b0, m_t, x_t);
    i_valid = 1'b1; i_mem_ren = 1'b1; i_mem_wen = 1'b0; i_funct3 = 3'b010;
    i_addr = 32'h100; i_reg_wena = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; busy = 1'b1; req_allowed = 1'b1; i_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_gnt = 1'b0; req_allowed = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0; busy = 1'b0;
    check("rst2_we", {31'h0, o_we}, 32'h0);
    check("rst2_err", {31'h0, o_err}, 32'h0);
    check("rst2_wena", {31'h0, o_reg_wena}, 32'h0);
    check("rst2_addr", o_addr, 32'h0);
    check("rst2_wdata", o_wdata, 32'h0);
    check("rst2_result", o_result, 32'h0);
    i_rsp_valid = 1'b1; i_rsp_data = 32'hDEAD_BEEF;
    @(posedge i_clk); #1;
    i_rsp_valid = 1'b0;
    check("late_rsp_valid", {31'h0, o_valid}, 32'h0);
    check("late_rsp_result", o_result, 32'h0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      ren = (kind == 1) || (kind == 3);
      wen = (kind == 2) || (kind == 3);
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      if (wen) f3[2] = 1'b0;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      run_txn(ren, wen, f3, a, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
